// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display path: segment order, hex glyph
// table and output polarity helper.
package seg7_pkg;

  localparam int unsigned SEG_BITS = 7;

  // Bit positions within seg_out, MSB..LSB = {g,f,e,d,c,b,a}
  typedef enum int unsigned {
    SEG_A = 0,
    SEG_B = 1,
    SEG_C = 2,
    SEG_D = 3,
    SEG_E = 4,
    SEG_F = 5,
    SEG_G = 6
  } seg_bit_e;

  // Active-high glyphs for 0..F (b and d are lower case)
  localparam logic [SEG_BITS-1:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } slot_phase_e;

  function automatic logic inactive_level(input bit active_low);
    return active_low;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to 7-segment glyph, active-high {g,f,e,d,c,b,a}.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0]          nibble,
  output logic [SEG_BITS-1:0] seg
);

  always_comb begin
    seg = HEX_SEG[nibble];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment scan driver with double-buffered digits,
// frame-boundary display update and a blanking gap at the start of every slot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] data_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic [DIGITS-1:0]   blank_in,
  input  logic                load,
  output logic [DIGITS-1:0]   an_out,
  output logic [SEG_BITS-1:0] seg_out,
  output logic                dp_out,
  output logic                frame_end
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic        INACT = inactive_level(ACTIVE_LOW);

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [DIG_W-1:0]    digit_q, digit_d;
  logic [4*DIGITS-1:0] pend_data_q, pend_data_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic                pend_valid_q, pend_valid_d;
  logic [4*DIGITS-1:0] disp_data_q, disp_data_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]   disp_blank_q, disp_blank_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [SEG_BITS-1:0] seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                frame_end_q, frame_end_d;

  logic                last_div, last_digit, lit, transfer;
  logic [3:0]          cur_nib;
  logic                cur_dp, cur_blank;
  logic [SEG_BITS-1:0] dec_seg;
  slot_phase_e         phase;

  seg7_hex_decoder u_dec (
    .nibble (cur_nib),
    .seg    (dec_seg)
  );

  always_comb begin
    last_div   = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
    last_digit = (digit_q == DIG_W'(DIGITS - 1));
    div_cnt_d  = last_div ? '0 : div_cnt_q + 1'b1;
    digit_d    = digit_q;
    if (last_div) begin
      digit_d = last_digit ? '0 : digit_q + 1'b1;
    end
    // Registered against the next counter state so the pulse lines up with
    // the cycle in which the counters sit at the end of the frame.
    frame_end_d = (digit_d == DIG_W'(DIGITS - 1)) && (div_cnt_d == DIV_W'(SCAN_DIV - 1));

    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (digit_q == DIG_W'(i)) begin
        cur_nib   = disp_data_q[4*i +: 4];
        cur_dp    = disp_dp_q[i];
        cur_blank = disp_blank_q[i];
      end
    end

    phase = (div_cnt_q < DIV_W'(BLANK_CYCLES)) ? PH_BLANK : PH_DRIVE;
    lit   = (phase == PH_DRIVE) && !cur_blank;

    an_d = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      an_d[i] = lit && (digit_q == DIG_W'(i));
    end
    seg_d = lit ? dec_seg : '0;
    dp_d  = lit && cur_dp;
    an_d  = an_d ^ {DIGITS{INACT}};
    seg_d = seg_d ^ {SEG_BITS{INACT}};
    dp_d  = dp_d ^ INACT;

    // frame_end_q is high exactly while the counters are at the frame's last cycle
    transfer     = frame_end_q && pend_valid_q;
    disp_data_d  = transfer ? pend_data_q : disp_data_q;
    disp_dp_d    = transfer ? pend_dp_q : disp_dp_q;
    disp_blank_d = transfer ? pend_blank_q : disp_blank_q;

    pend_data_d  = load ? data_in : pend_data_q;
    pend_dp_d    = load ? dp_in : pend_dp_q;
    pend_blank_d = load ? blank_in : pend_blank_q;
    pend_valid_d = load ? 1'b1 : (transfer ? 1'b0 : pend_valid_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q    <= '0;
      digit_q      <= '0;
      pend_data_q  <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '1;
      pend_valid_q <= 1'b0;
      disp_data_q  <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '1;
      an_q         <= {DIGITS{INACT}};
      seg_q        <= {SEG_BITS{INACT}};
      dp_q         <= INACT;
      frame_end_q  <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      digit_q      <= digit_d;
      pend_data_q  <= pend_data_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      pend_valid_q <= pend_valid_d;
      disp_data_q  <= disp_data_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_end_q  <= frame_end_d;
    end
  end

  assign an_out    = an_q;
  assign seg_out   = seg_q;
  assign dp_out    = dp_q;
  assign frame_end = frame_end_q;

endmodule
